// File: rtl/aurora_rx_frame_buffer_pkg.sv
// aurora_rx_frame_buffer_pkg: write-FSM encodings and frame resolution codes
package aurora_rx_frame_buffer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WAIT_CRC = 2'd2} wr_state_e;
  typedef enum logic [2:0] {RES_NONE, RES_GOOD, RES_CRC, RES_OVF, RES_ERR} res_e;
  function automatic res_e resolve(input logic ovf, input logic err, input logic pass);
    return ovf ? RES_OVF : err ? RES_ERR : pass ? RES_GOOD : RES_CRC;
  endfunction
endpackage

// File: rtl/aurora_sdp_ram.sv
// aurora_sdp_ram: simple dual-port RAM, one write port and one registered read port
module aurora_sdp_ram #(
  parameter int W = 37,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [1<<AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/aurora_rx_frame_buffer.sv
// aurora_rx_frame_buffer: speculative frame FIFO that releases only CRC-clean frames, with NFC XOFF and drop counters
module aurora_rx_frame_buffer
  import aurora_rx_frame_buffer_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int DEPTH_LOG2  = 9,
  parameter int XOFF_THRESH = 64,
  parameter int XON_THRESH  = 128,
  parameter int CNT_W       = 16
) (
  input  logic                    user_clk,
  input  logic                    reset,
  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_crc_valid,
  input  logic                    s_axis_crc_pass_fail_n,
  output logic [8*DATA_BYTES-1:0] m_axis_tdata,
  output logic [DATA_BYTES-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    nfc_xoff,
  output logic [CNT_W-1:0]        cnt_good,
  output logic [CNT_W-1:0]        cnt_crc_drop,
  output logic [CNT_W-1:0]        cnt_ovf_drop,
  output logic [CNT_W-1:0]        cnt_err_drop
);
  localparam int P = DEPTH_LOG2 + 1;
  localparam int W = 8*DATA_BYTES + DATA_BYTES + 1;
  localparam logic [P-1:0] DEPTH = P'(1 << DEPTH_LOG2);
  localparam logic [P-1:0] XOFF = P'(XOFF_THRESH);
  localparam logic [P-1:0] XON = P'(XON_THRESH);
  wr_state_e state, state_n;
  res_e res;
  logic err_flag, ovf_flag, err_n, ovf_n, we, re, move, full, ram_valid, out_valid;
  logic [P-1:0] wr_ptr, wr_commit, rd_ptr, free;
  logic [W-1:0] ram_q, out_q;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_q;
  assign m_axis_tvalid = out_valid;
  aurora_sdp_ram #(.W(W), .AW(DEPTH_LOG2)) u_ram (
    .clk(user_clk),
    .we(we),
    .waddr(wr_ptr[DEPTH_LOG2-1:0]),
    .wdata({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .re(re),
    .raddr(rd_ptr[DEPTH_LOG2-1:0]),
    .rdata(ram_q)
  );
  always_comb begin
    full = (wr_ptr - rd_ptr) == DEPTH;
    free = DEPTH - (wr_ptr - rd_ptr);
    state_n = state;
    err_n = state == IDLE ? 1'b0 : err_flag;
    ovf_n = state == IDLE ? 1'b0 : ovf_flag;
    res = RES_NONE;
    we = 1'b0;
    if (s_axis_tvalid && state != WAIT_CRC) begin
      err_n = err_n | s_axis_tuser;
      ovf_n = ovf_n | full;
      we = !ovf_n;
      state_n = s_axis_tlast ? WAIT_CRC : RECV;
      if (s_axis_tlast && s_axis_crc_valid) begin
        state_n = IDLE;
        res = resolve(ovf_n, err_n, s_axis_crc_pass_fail_n);
      end
    end else if (state == WAIT_CRC && (s_axis_tvalid || s_axis_crc_valid)) begin
      state_n = IDLE;
      res = s_axis_tvalid ? RES_ERR : resolve(ovf_flag, err_flag, s_axis_crc_pass_fail_n);
    end
    // RAM stage refills whenever it is empty or hands its word to the output register
    move = ram_valid && (!out_valid || m_axis_tready);
    re = rd_ptr != wr_commit && (!ram_valid || move);
  end
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state <= IDLE;
      err_flag <= 1'b0;
      ovf_flag <= 1'b0;
      wr_ptr <= '0;
      wr_commit <= '0;
      rd_ptr <= '0;
      ram_valid <= 1'b0;
      out_valid <= 1'b0;
      out_q <= '0;
      nfc_xoff <= 1'b0;
      cnt_good <= '0;
      cnt_crc_drop <= '0;
      cnt_ovf_drop <= '0;
      cnt_err_drop <= '0;
    end else begin
      state <= state_n;
      err_flag <= err_n;
      ovf_flag <= ovf_n;
      wr_ptr <= res inside {RES_CRC, RES_OVF, RES_ERR} ? wr_commit : wr_ptr + P'(we);
      if (res == RES_GOOD) wr_commit <= wr_ptr + P'(we);
      rd_ptr <= rd_ptr + P'(re);
      ram_valid <= re || (ram_valid && !move);
      out_valid <= move || (out_valid && !m_axis_tready);
      if (move) out_q <= ram_q;
      nfc_xoff <= free < XOFF ? 1'b1 : free >= XON ? 1'b0 : nfc_xoff;
      if (res == RES_GOOD && !(&cnt_good)) cnt_good <= cnt_good + 1'b1;
      if (res == RES_CRC && !(&cnt_crc_drop)) cnt_crc_drop <= cnt_crc_drop + 1'b1;
      if (res == RES_OVF && !(&cnt_ovf_drop)) cnt_ovf_drop <= cnt_ovf_drop + 1'b1;
      if (res == RES_ERR && !(&cnt_err_drop)) cnt_err_drop <= cnt_err_drop + 1'b1;
    end
  end
endmodule

// File: tb/tb_aurora_rx_frame_buffer.sv
// tb_aurora_rx_frame_buffer: directed vectors and frame sequences for the buffered RX stage
module tb_aurora_rx_frame_buffer;
  logic user_clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] s_tdata, m_tdata;
  logic [3:0] s_tkeep, m_tkeep, c_good, c_crc, c_ovf, c_err;
  logic s_tvalid, s_tuser, s_tlast, crc_v, crc_p;
  logic m_tlast, m_tvalid, m_tready, xoff;
  logic [36:0] got[$], exp[$];
  int n_vec = 0, n_bad = 0, sent;
  bit rnd = 1'b0;
  typedef struct {
    logic v; logic [31:0] d; logic [3:0] k; logic l, cv, cp;
    logic ev; logic [31:0] ed; logic [3:0] ek; logic el; logic [3:0] eg;
  } vec_t;
  vec_t tbl[10];
  always #5 user_clk = ~user_clk;
  aurora_rx_frame_buffer #(.DATA_BYTES(4), .DEPTH_LOG2(4), .XOFF_THRESH(4), .XON_THRESH(8), .CNT_W(4)) dut (
    .user_clk(user_clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_crc_valid(crc_v), .s_axis_crc_pass_fail_n(crc_p),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .nfc_xoff(xoff),
    .cnt_good(c_good), .cnt_crc_drop(c_crc), .cnt_ovf_drop(c_ovf), .cnt_err_drop(c_err)
  );
  always @(negedge user_clk) if (!reset && m_tvalid && m_tready) got.push_back({m_tlast, m_tkeep, m_tdata});
  task automatic tick();
    if (rnd) m_tready = 1'($urandom_range(0, 1));
    @(posedge user_clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  task automatic idle_in();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; crc_v = 1'b0; crc_p = 1'b0;
    s_tdata = '0; s_tkeep = '0;
  endtask
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u, input logic cv, input logic cp);
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; crc_v = cv; crc_p = cp;
    tick();
    idle_in();
  endtask
  task automatic send_frame(input logic [31:0] base, input int n, input int bad, input logic cv, input logic pass, input bit keep_it);
    for (int i = 0; i < n; i++) begin
      logic l;
      logic [3:0] k;
      l = (i == n - 1);
      k = l ? 4'h3 : 4'hF;
      send(base + 32'(i), k, l, i == bad, cv && l, pass);
      if (keep_it) exp.push_back({l, k, base + 32'(i)});
    end
  endtask
  task automatic verdict(input logic pass);
    crc_v = 1'b1; crc_p = pass;
    tick();
    idle_in();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    reset = 1'b0;
    got.delete();
    exp.delete();
  endtask
  task automatic wait_got(input int n);
    for (int w = 0; w < 300 && got.size() < n; w++) tick();
  endtask
  task automatic cmp_stream(input string nm);
    chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk({nm, "_beat"}, 64'(got[i]), 64'(exp[i]));
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, {m_tdata, m_tkeep, m_tlast, m_tvalid, xoff, c_good, c_crc, c_ovf, c_err}, 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1'b1, 32'hA000_0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 4'd0};
    tbl[1] = '{1'b1, 32'hA000_0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 4'd0};
    tbl[2] = '{1'b1, 32'hA000_0002, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 4'd0};
    tbl[3] = '{1'b1, 32'hA000_0003, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd1};
    tbl[4] = '{1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 4'd1};
    tbl[5] = '{1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0000, 4'hF, 1'b0, 4'd1};
    tbl[6] = '{1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0001, 4'hF, 1'b0, 4'd1};
    tbl[7] = '{1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0002, 4'hF, 1'b0, 4'd1};
    tbl[8] = '{1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0003, 4'h3, 1'b1, 4'd1};
    tbl[9] = '{1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 4'd1};
    idle_in();
    m_tready = 1'b1;
    tick();
    tick();
    chk_zero("reset_outs");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = tbl[i].v; s_tdata = tbl[i].d; s_tkeep = tbl[i].k; s_tlast = tbl[i].l;
      crc_v = tbl[i].cv; crc_p = tbl[i].cp; s_tuser = 1'b0;
      tick();
      idle_in();
      chk("t1_valid", 64'(m_tvalid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("t1_data", 64'(m_tdata), 64'(tbl[i].ed));
        chk("t1_keep", 64'(m_tkeep), 64'(tbl[i].ek));
        chk("t1_last", 64'(m_tlast), 64'(tbl[i].el));
      end
      chk("t1_good", 64'(c_good), 64'(tbl[i].eg));
    end
    do_reset();
    send_frame(32'hB000_0000, 4, -1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    verdict(1'b0);
    repeat (6) tick();
    chk("t2_crc_drop", 64'(c_crc), 64'd1);
    chk("t2_no_out", 64'(got.size()), 64'd0);
    send_frame(32'hC000_0000, 4, -1, 1'b1, 1'b1, 1'b1);
    wait_got(4);
    tick();
    cmp_stream("t2_after_rewind");
    chk("t2_good", 64'(c_good), 64'd1);
    do_reset();
    send_frame(32'hD000_0000, 4, 1, 1'b1, 1'b1, 1'b0);
    repeat (6) tick();
    chk("t3_err_drop", 64'(c_err), 64'd1);
    chk("t3_good", 64'(c_good), 64'd0);
    chk("t3_no_out", 64'(got.size()), 64'd0);
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(32'hE000_0000 + 32'(i), 4'hF, i == 19, 1'b0, i == 19, 1'b1);
      if (i == 12) chk("t4_xoff_free4", 64'(xoff), 64'd0);
      if (i == 13) chk("t4_xoff_free3", 64'(xoff), 64'd1);
    end
    chk("t4_ovf_drop", 64'(c_ovf), 64'd1);
    chk("t4_good", 64'(c_good), 64'd0);
    tick();
    tick();
    chk("t4_xoff_rewind", 64'(xoff), 64'd0);
    m_tready = 1'b1;
    repeat (4) tick();
    chk("t4_no_out", 64'(got.size()), 64'd0);
    do_reset();
    m_tready = 1'b0;
    send_frame(32'hE100_0000, 14, -1, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    chk("t4b_xoff_hold", 64'(xoff), 64'd1);
    chk("t4b_stall_valid", 64'(m_tvalid), 64'd1);
    chk("t4b_stall_data", 64'(m_tdata), 64'hE100_0000);
    m_tready = 1'b1;
    tick();
    chk("t4b_xoff_free5", 64'(xoff), 64'd1);
    wait_got(14);
    tick();
    chk("t4b_xoff_clear", 64'(xoff), 64'd0);
    cmp_stream("t4b_drain");
    do_reset();
    rnd = 1'b1;
    sent = 0;
    for (int f = 0; f < 24; f++) begin
      int w;
      for (w = 0; w < 300 && sent - got.size() > 10; w++) tick();
      if (w == 300) chk("t5_space_wait", 64'(sent - got.size()), 64'd10);
      send_frame(32'h5000_0000 + 32'(f * 16), 2, -1, 1'b1, 1'b1, 1'b1);
      sent += 2;
    end
    rnd = 1'b0;
    m_tready = 1'b1;
    wait_got(48);
    tick();
    cmp_stream("t5_wrap");
    chk("t5_good_sat", 64'(c_good), 64'd15);
    chk("t5_ovf", 64'(c_ovf), 64'd0);
    do_reset();
    m_tready = 1'b0;
    send_frame(32'hF000_0000, 2, -1, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("t6_stall_valid", 64'(m_tvalid), 64'd1);
    chk("t6_good", 64'(c_good), 64'd1);
    send(32'hF100_0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'hF100_0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("t6_reset_outs");
    got.delete();
    exp.delete();
    m_tready = 1'b1;
    send_frame(32'h6000_0000, 3, -1, 1'b1, 1'b1, 1'b1);
    wait_got(3);
    tick();
    cmp_stream("t6_after_reset");
    chk("t6_good_after", 64'(c_good), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
